// File: rtl/jk_updown_counter_pkg.sv
// Shared constants and helpers for the JK-flip-flop based up/down counter.
package jk_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Clamp a parallel-load value to the programmed modulus (widest legal counter is 16 bits).
    function automatic logic [15:0] sat_load(input logic [15:0] d, input logic [15:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle between the counter and whatever drives it.
interface jk_updown_counter_if
    import jk_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (output en, output up_dn, output load, output d, input q, input tc);
    modport slave  (input en, input up_dn, input load, input d, output q, output tc);
endinterface

// File: rtl/jk_updown_counter_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle; async active-low clear.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jk_updown_counter.sv
// Modulo up/down counter whose state lives entirely in JK cells; this level only
// computes the per-cell J/K drive and the combinational terminal-count flag.
module jk_updown_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic                clk,
    input  logic                rst,
    jk_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (w_q == MAX_Q);
    assign w_at_zero = (w_q == '0);

    // d and up_dn are only looked at on the branch that uses them, so unknowns there cannot reach a cell while holding.
    always_comb begin
        w_next_q = w_q;
        w_t      = '0;
        w_j      = '0;
        w_k      = '0;
        if (bus.load) begin
            w_next_q = WIDTH'(sat_load(16'(bus.d), 16'(MAX_Q)));
            w_j      = w_next_q;
            w_k      = ~w_next_q;
        end else if (bus.en) begin
            if (bus.up_dn == DIR_UP) begin
                w_next_q = w_at_max ? '0 : w_q + 1'b1;
            end else begin
                w_next_q = w_at_zero ? MAX_Q : w_q - 1'b1;
            end
            w_t = w_q ^ w_next_q;
            w_j = w_t;
            w_k = w_t;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .i_j (w_j[i]),
            .i_k (w_k[i]),
            .o_q (w_q[i])
        );
    end

    assign bus.q  = w_q;
    assign bus.tc = bus.en & ~bus.load &
                    ((bus.up_dn & w_at_max) | (~bus.up_dn & w_at_zero));
endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Synchronous N-bit up/down counter built entirely from JK flip-flop cells. Per-bit J/K drive logic is derived from the current count, direction and load.
- Sits directly downstream of the JK flip-flop stage: it consumes JK cell outputs (q) and generates their J/K inputs.
- Serves as the standard modulo counter / divider for the sequential-circuits set.
- Provides parallel load, enable, programmable modulus and a terminal-count flag.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MAX_COUNT, 2**WIDTH-1, highest count value; counting is modulo MAX_COUNT+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 clears immediately, regardless of clk).
- en  input  1  count enable; sampled on rising clk.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load; takes priority over en.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (the JK cell outputs).
- tc  output  1  terminal count, combinational.

Behaviour:
- Reset:
  - rst=0 forces q=0 asynchronously; tc then follows its equation.
  - Release of rst is synchronous in effect: the first count/load happens on the first rising clk with rst=1.
- Priority per rising edge: rst low > load > en > hold.
- Load:
  - q <= d in one cycle.
  - If d > MAX_COUNT, q <= MAX_COUNT (saturate). Only possible when MAX_COUNT < 2**WIDTH-1.
- Count, en=1 and load=0:
  - up_dn=1: q <= (q==MAX_COUNT) ? 0 : q+1.
  - up_dn=0: q <= (q==0) ? MAX_COUNT : q-1.
- Hold, en=0 and load=0: every cell gets J=K=0; q unchanged.
- JK drive rules:
  - Each bit i is driven as a toggle cell: J=K=t[i], where t is the bitwise XOR of q and next_q.
  - For a load, J=next_q[i], K=~next_q[i] (set/reset form).
  - Never drive J=K=1 except when a toggle is intended.
- Latency: q changes one clock after inputs are sampled. No pipeline bubble between load and count.
- tc = en & ~load & ((up_dn & q==MAX_COUNT) | (~up_dn & q==0)).
  - High exactly in the cycle before wrap-around.
  - Combinational from the inputs and q; no registered copy.
- Direction change mid-count: takes effect on the next edge with no lost or extra step (e.g. 5 up -> 6, then down -> 5).
- Simultaneous load and en: load wins; tc is 0 that cycle.
- Reset asserted mid-count or mid-load: q goes to 0 without waiting for clk; a pending load is discarded.
- X/Z handling:
  - X on up_dn or d while en=0 and load=0 must not disturb q.
  - After reset release, q is never X.

Decomposition:
- Shared package jk_counter_pkg:
  - Constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - Function sat_load(d, max) for the load clamp.
  - Localparam default WIDTH=4.
- One sub-module, jk_cell: a single JK flip-flop with async active-low rst.
  - Truth table: 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times by generate.
- The counter top contains only next-state/J-K drive logic and tc.

Test Plan:
- Reset: rst=0 at t=0 with en=1, then release -> q=0 while rst=0; assert rst=0 asynchronously mid-cycle at q=9 -> q=0 before the next edge.
- Up-count wrap, WIDTH=4 default: en=1, up_dn=1 for 17 cycles from 0 -> q steps 0..15 then 0; tc=1 only while q=15.
- Down-count with modulus, MAX_COUNT=9: load d=2, then en=1, up_dn=0 -> q = 2,1,0,9,8; tc=1 only while q=0.
- Load priority and saturation, MAX_COUNT=9: at q=4, load=1, en=1, d=7 -> q=7, tc=0; then load with d=13 -> q=9.
- Hold and direction flip: en=0 for 3 cycles at q=6 -> q stays 6; then en=1, up_dn=1 -> q=7; up_dn=0 -> q=6.
- Per-cell check: probe jk_cell J/K every cycle of the up-count run -> J==K on all count cycles, J=K=0 during hold, and no 1/1 on bits that do not change.
